// File: rtl/echo_processor.sv
// Echo processor: offset-binary samples in, dry + attenuated delayed echo out,
// feed-forward or recursive. Define ECHO_SAT_EN to saturate instead of wrap.
module echo_processor #(
  parameter int                DATA_W     = 10,
  parameter int                ADDR_W     = 13,
  parameter logic [DATA_W-1:0] ADC_OFFSET = 10'h181,
  parameter logic [DATA_W-1:0] DAC_OFFSET = 10'h200,
  parameter int                DRY_SHIFT  = 2,
  parameter int                WET_SHIFT  = 1
) (
  input  logic              sysclk,
  input  logic              rst_n,
  input  logic              pulse,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] delay,
  input  logic              mode,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              primed,
  output logic              clip
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int YW    = DATA_W + DRY_SHIFT + 1;
  localparam int FW    = DATA_W + 1;
  localparam int CW    = ADDR_W + 1;

  typedef enum logic {PRIME, RUN} state_t;

  state_t            state, state_next;
  logic [CW-1:0]     fill_cnt, fill_next;
  logic [ADDR_W-1:0] delay_q;
  logic [ADDR_W-1:0] eff_delay;
  logic              delay_chg;

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] x;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;

  logic              s1_valid;
  logic [DATA_W-1:0] s1_x;
  logic              s1_mode;
  logic              s1_primed;
  logic [ADDR_W-1:0] s1_addr;

  logic signed [DATA_W-1:0] e_s, e_att;
  logic signed [YW-1:0]     x_ext, e_ext, y_full;
  logic        [FW-1:0]     fb_full;
  logic        [DATA_W-1:0] y_res, fb_res;
  logic                     y_ovf;

  // Delays of 0 and 1 would read a slot that is still being written.
  assign eff_delay = (delay < ADDR_W'(2)) ? ADDR_W'(2) : delay;
  assign delay_chg = (delay != delay_q);
  assign x         = data_in - ADC_OFFSET;
  assign rd_addr   = wr_ptr - eff_delay;
  assign primed    = (state == RUN);

  // ---------------- fill state machine ----------------
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; a missing default infers a latch.
  always_comb begin
    state_next = state;
    fill_next  = fill_cnt;
    if (delay_chg) begin
      state_next = PRIME;
      fill_next  = pulse ? CW'(1) : '0;
    end else if (state == PRIME && pulse) begin
      fill_next = fill_cnt + CW'(1);
      if (fill_next >= {1'b0, eff_delay}) state_next = RUN;
    end
  end

  // NOTE: registered state uses non-blocking assignments so every flop in the
  // design samples the pre-edge values, independent of block ordering.
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      state    <= PRIME;
      fill_cnt <= '0;
      delay_q  <= delay;
      wr_ptr   <= '0;
    end else begin
      state    <= state_next;
      fill_cnt <= fill_next;
      delay_q  <= delay;
      if (pulse) wr_ptr <= wr_ptr + ADDR_W'(1);
    end
  end

  // ---------------- delay RAM ----------------
  // NOTE: the RAM has no reset; stale contents are masked by PRIME, and a
  // reset port would prevent block-RAM inference.
  always_ff @(posedge sysclk) begin
    if (wr_en) mem[s1_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

  // ---------------- stage 1: sample waits for its echo ----------------
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_x      <= '0;
      s1_mode   <= 1'b0;
      s1_primed <= 1'b0;
      s1_addr   <= '0;
    end else begin
      s1_valid  <= pulse;
      if (pulse) begin
        s1_x      <= x;
        s1_mode   <= mode;
        // A delay change in the same cycle already starts a new fill.
        s1_primed <= primed && !delay_chg;
        s1_addr   <= wr_ptr;
      end
    end
  end

  // ---------------- mix ----------------
  assign e_s     = s1_primed ? rd_data : '0;
  assign e_att   = e_s >>> WET_SHIFT;
  assign x_ext   = {{(YW - DATA_W){s1_x[DATA_W-1]}}, s1_x};
  assign e_ext   = {{(YW - DATA_W){e_att[DATA_W-1]}}, e_att};
  assign y_full  = (x_ext <<< DRY_SHIFT) + e_ext;
  assign fb_full = {s1_x[DATA_W-1], s1_x} + {e_att[DATA_W-1], e_att};

`ifdef ECHO_SAT_EN
  // Out of range when the bits above the result's sign are not all copies of it.
  assign y_ovf  = (y_full[YW-1:DATA_W-1] != {(YW - DATA_W + 1){y_full[YW-1]}});
  assign y_res  = y_ovf ? {y_full[YW-1], {(DATA_W - 1){~y_full[YW-1]}}}
                        : y_full[DATA_W-1:0];
  logic fb_ovf;
  assign fb_ovf = (fb_full[FW-1] != fb_full[FW-2]);
  assign fb_res = fb_ovf ? {fb_full[FW-1], {(DATA_W - 1){~fb_full[FW-1]}}}
                         : fb_full[DATA_W-1:0];
`else
  assign y_ovf  = 1'b0;
  assign y_res  = y_full[DATA_W-1:0];
  assign fb_res = fb_full[DATA_W-1:0];
  logic unused_hi;
  assign unused_hi = ^{y_full[YW-1:DATA_W], fb_full[FW-1]};
`endif

  assign wr_en   = s1_valid && rst_n;
  assign wr_data = s1_mode ? fb_res : s1_x;

  // ---------------- output register ----------------
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      data_out  <= DAC_OFFSET;
      valid_out <= 1'b0;
      clip      <= 1'b0;
    end else begin
      valid_out <= s1_valid;
      clip      <= s1_valid && y_ovf;
      if (s1_valid) data_out <= y_res + DAC_OFFSET;
    end
  end

endmodule

// File: tb/tb_echo_processor.sv
// Self-checking bench for echo_processor: scoreboard queue filled at each pulse,
// drained when valid_out appears. Expectations follow ECHO_SAT_EN if defined.
module tb_echo_processor;

  logic        sysclk = 1'b0;
  logic        rst_n;
  logic        pulse;
  logic [9:0]  data_in;
  logic [12:0] delay;
  logic        mode;
  logic [9:0]  data_out;
  logic        valid_out;
  logic        primed;
  logic        clip;

  echo_processor dut (
    .sysclk    (sysclk),
    .rst_n     (rst_n),
    .pulse     (pulse),
    .data_in   (data_in),
    .delay     (delay),
    .mode      (mode),
    .data_out  (data_out),
    .valid_out (valid_out),
    .primed    (primed),
    .clip      (clip)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    logic [9:0] data;
    logic       clip;
    int         due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference model state
  int hist [8192];
  int mwp, mfill, mdelay;

  always @(posedge sysclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge sysclk) begin
    if (valid_out === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("data_out", data_out, e.data);
        check("clip", clip, e.clip);
        check("latency", cyc, e.due);
      end
    end
  end

  function automatic int fit(input int v, output bit c);
`ifdef ECHO_SAT_EN
    c = (v > 511) || (v < -512);
    if (v > 511) return 511;
    if (v < -512) return -512;
    return v;
`else
    int w;
    c = 1'b0;
    w = v & 1023;
    if (w > 511) w -= 1024;
    return w;
`endif
  endfunction

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic model_reset();
    mwp   = 0;
    mfill = 0;
  endtask

  // Drive one sample; push either the given constant or the model's prediction.
  task automatic send(input logic [9:0] d, input logic m, input bit use_model,
                      input logic [9:0] exp_d, input logic exp_c, input bit push);
    int   x, eff, e, ea, y, w;
    bit   c, cw;
    exp_t item;
    x = int'(d) - 'h181;
    if (x > 511) x -= 1024;
    eff = (mdelay < 2) ? 2 : mdelay;
    e   = (mfill >= eff) ? hist[(mwp - eff) & 8191] : 0;
    ea  = e >>> 1;
    y   = fit(4 * x + ea, c);
    w   = m ? fit(x + ea, cw) : x;
    hist[mwp & 8191] = w;
    mwp++;
    if (mfill < eff) mfill++;
    item.due  = cyc + 2;
    item.data = use_model ? 10'((y + 512) & 1023) : exp_d;
    item.clip = use_model ? c : exp_c;
    if (push) sb.push_back(item);
    pulse   = 1'b1;
    data_in = d;
    mode    = m;
    tick();
    pulse   = 1'b0;
  endtask

  task automatic set_delay(input int d);
    delay  = 13'(d);
    mdelay = d;
    mfill  = 0;
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pulse = 1'b0;
    tick();
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n && sb.size() != 0; i++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; pulse = 1'b0; data_in = '0; delay = 13'd4; mode = 1'b0;
    mdelay = 4;
    model_reset();
    tick();
    pulse = 1'b1; data_in = 10'h191;   // must be ignored while in reset
    tick();
    pulse = 1'b0;
    check("rst_data_out", data_out, 10'h200);
    check("rst_valid", valid_out, 1'b0);
    check("rst_primed", primed, 1'b0);
    check("rst_clip", clip, 1'b0);
    rst_n = 1'b1;

    // Feed-forward, delay 4, constant x=16
    for (int i = 0; i < 8; i++) begin
      send(10'h191, 1'b0, 1'b0, (i < 4) ? 10'h240 : 10'h248, 1'b0, 1'b1);
      if (i == 2) check("primed_after_3", primed, 1'b0);
      if (i == 3) check("primed_after_4", primed, 1'b1);
    end
    repeat (3) tick();
    check("hold_data", data_out, 10'h248);
    check("hold_valid", valid_out, 1'b0);
    check("hold_clip", clip, 1'b0);

    // Delay change 4 -> 6 re-primes without echo
    set_delay(6);
    check("primed_drop", primed, 1'b0);
    for (int i = 0; i < 6; i++) send(10'h191, 1'b0, 1'b0, 10'h240, 1'b0, 1'b1);
    check("primed_after_6", primed, 1'b1);
    send(10'h191, 1'b0, 1'b0, 10'h248, 1'b0, 1'b1);
    drain(5);

    // delay 0 behaves as 2
    set_delay(0);
    check("primed_d0_drop", primed, 1'b0);
    send(10'h191, 1'b0, 1'b0, 10'h240, 1'b0, 1'b1);
    send(10'h181, 1'b0, 1'b0, 10'h200, 1'b0, 1'b1);
    check("primed_d0", primed, 1'b1);
    send(10'h181, 1'b0, 1'b0, 10'h208, 1'b0, 1'b1);
    send(10'h181, 1'b0, 1'b0, 10'h200, 1'b0, 1'b1);
    drain(5);

    // Recursive echo, delay 2, impulse
    delay = 13'd2; mdelay = 2;
    do_reset();
    begin
      logic [9:0] fb_exp [7];
      fb_exp = '{10'h240, 10'h200, 10'h208, 10'h200, 10'h204, 10'h200, 10'h202};
      for (int i = 0; i < 7; i++)
        send((i == 0) ? 10'h191 : 10'h181, 1'b1, 1'b0, fb_exp[i], 1'b0, 1'b1);
    end
    drain(5);

    // Range limits with no echo
    delay = 13'd4; mdelay = 4;
    do_reset();
`ifdef ECHO_SAT_EN
    send(10'h27F, 1'b0, 1'b0, 10'h3FF, 1'b1, 1'b1);
    send(10'h000, 1'b0, 1'b0, 10'h000, 1'b1, 1'b1);
`else
    send(10'h27F, 1'b0, 1'b0, 10'h1F8, 1'b0, 1'b1);
    send(10'h000, 1'b0, 1'b0, 10'h3FC, 1'b0, 1'b1);
`endif
    drain(5);

    // Reset while a sample is in flight discards it
    send(10'h191, 1'b0, 1'b0, 10'h240, 1'b0, 1'b0);
    do_reset();
    check("midrst_data", data_out, 10'h200);
    check("midrst_valid", valid_out, 1'b0);
    check("midrst_primed", primed, 1'b0);
    send(10'h191, 1'b0, 1'b0, 10'h240, 1'b0, 1'b1);
    drain(5);

    // Random data and modes against the model, with a delay change midway
    delay = 13'd3; mdelay = 3;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      if (i == 30) set_delay(5);
      send(10'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)), 1'b1, '0, 1'b0, 1'b1);
      if ($urandom_range(0, 3) == 0) tick();
    end
    drain(10);
    check("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
